// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing the single core-to-dcache request port between NUM_REQ requesters.
// One request is in flight at a time; a watchdog aborts loads whose data never returns.
module dcache_port_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ-1:0][31:0]   i_req_addr,
  input  logic [NUM_REQ-1:0][63:0]   i_req_data,
  input  logic [NUM_REQ-1:0]         i_req_we,
  input  logic [NUM_REQ-1:0][1:0]    i_req_size,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic [NUM_REQ-1:0]         o_resp_valid,
  output logic [63:0]                o_resp_data,
  output logic                       o_core2dcache_req_valid,
  output logic [31:0]                o_core2dcache_addr,
  output logic [63:0]                o_core2dcache_data,
  output logic                       o_core2dcache_data_we,
  output logic [1:0]                 o_core2dcache_data_size,
  input  logic [63:0]                i_dcache2core_data,
  input  logic                       i_dcache2core_data_valid,
  output logic                       o_timeout_err
);

  localparam int                IDX_W      = $clog2(NUM_REQ);
  localparam logic [IDX_W:0]    NUM_REQ_W  = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0]  NUM_REQ_LO = IDX_W'(NUM_REQ);
  localparam logic [CNT_W-1:0]  TIMEOUT_W  = CNT_W'(TIMEOUT_CYCLES);
  localparam bit                WDOG_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [31:0]        r_addr;
  logic [63:0]        r_data;
  logic               r_we;
  logic [1:0]         r_size;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [63:0]        r_resp_data;
  logic               r_timeout_err;

  logic [IDX_W-1:0]   w_cand [NUM_REQ];
  logic               w_grant_vld;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_busy;
  logic               w_accept;
  logic               w_done;
  logic               w_timeout;
  logic               w_finish;

  // w_cand[k] is requester (last_grant + k + 1) mod NUM_REQ: the k-th in round-robin order
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_W:0] w_sum;
    assign w_sum       = {1'b0, r_last_grant} + (IDX_W+1)'(gi + 1);
    assign w_cand[gi]  = (w_sum >= NUM_REQ_W) ? (w_sum[IDX_W-1:0] - NUM_REQ_LO)
                                              : w_sum[IDX_W-1:0];
  end

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req_valid[w_cand[k]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand[k];
      end
    end
  end

  assign w_busy    = (r_state == ST_BUSY);
  assign w_accept  = (r_state == ST_IDLE) && w_grant_vld;
  assign w_done    = w_busy && (r_we || i_dcache2core_data_valid);
  // A completion in the same cycle as expiry wins over the abort
  assign w_timeout = WDOG_EN && w_busy && !w_done && (r_cnt == TIMEOUT_W);
  assign w_finish  = w_done || w_timeout;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_BUSY;
      ST_BUSY: if (w_finish) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign o_req_ready[gi] = w_accept && (w_grant_idx == IDX_W'(gi));
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_last_grant  <= IDX_W'(NUM_REQ - 1);
      r_gnt_idx     <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      r_we          <= 1'b0;
      r_size        <= '0;
      r_cnt         <= '0;
      r_resp_valid  <= '0;
      r_resp_data   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_resp_valid <= '0;
      if (w_accept) begin
        r_gnt_idx    <= w_grant_idx;
        r_last_grant <= w_grant_idx;
        r_addr       <= i_req_addr[w_grant_idx];
        r_data       <= i_req_data[w_grant_idx];
        r_we         <= i_req_we[w_grant_idx];
        r_size       <= i_req_size[w_grant_idx];
        r_cnt        <= '0;
      end else if (w_busy && !w_finish) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_finish) begin
        r_resp_valid[r_gnt_idx] <= 1'b1;
        r_resp_data             <= (w_done && !r_we) ? i_dcache2core_data : 64'd0;
        if (w_timeout) begin
          r_timeout_err <= 1'b1;
        end
      end
    end
  end

  // The dcache port is driven only while a request is in flight
  assign o_core2dcache_req_valid = w_busy;
  assign o_core2dcache_addr      = w_busy ? r_addr : 32'd0;
  assign o_core2dcache_data      = w_busy ? r_data : 64'd0;
  assign o_core2dcache_data_we   = w_busy && r_we;
  assign o_core2dcache_data_size = w_busy ? r_size : 2'd0;

  assign o_resp_valid  = r_resp_valid;
  assign o_resp_data   = r_resp_data;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: two requesters, watchdog shortened to 4 cycles.
module tb_dcache_port_arbiter;

  localparam int NUM_REQ = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0][31:0]  req_addr;
  logic [NUM_REQ-1:0][63:0]  req_data;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ-1:0][1:0]   req_size;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [63:0]               resp_data;
  logic                      dc_req_valid;
  logic [31:0]               dc_addr;
  logic [63:0]               dc_wdata;
  logic                      dc_we;
  logic [1:0]                dc_size;
  logic [63:0]               dc_rdata;
  logic                      dc_rvalid;
  logic                      timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dcache_port_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (4),
    .CNT_W          (8)
  ) dut (
    .i_clock                  (clk),
    .i_reset                  (rst_n),
    .i_req_valid              (req_valid),
    .i_req_addr               (req_addr),
    .i_req_data               (req_data),
    .i_req_we                 (req_we),
    .i_req_size               (req_size),
    .o_req_ready              (req_ready),
    .o_resp_valid             (resp_valid),
    .o_resp_data              (resp_data),
    .o_core2dcache_req_valid  (dc_req_valid),
    .o_core2dcache_addr       (dc_addr),
    .o_core2dcache_data       (dc_wdata),
    .o_core2dcache_data_we    (dc_we),
    .o_core2dcache_data_size  (dc_size),
    .i_dcache2core_data       (dc_rdata),
    .i_dcache2core_data_valid (dc_rvalid),
    .o_timeout_err            (timeout_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input logic r, input logic v, input logic we,
                         input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz);
    req_valid[r] = v;
    req_we[r]    = we;
    req_addr[r]  = a;
    req_data[r]  = d;
    req_size[r]  = sz;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [1:0] exp_rdy;
    logic [1:0] exp_rsp;
    logic [31:0] exp_a;

    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    req_we = '0; req_size = '0; dc_rdata = '0; dc_rvalid = 1'b0;
    next_cyc(); next_cyc(); smp();
    check("rst_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_dc_valid", dc_req_valid, 0);
    check("rst_timeout", timeout_err, 0);
    next_cyc();
    rst_n = 1'b1;

    // Test 1: load on requester 0, data returns at T+3
    set_req(1'b0, 1'b1, 1'b0, 32'h1000, 64'd0, 2'd2);
    smp();
    check("t1_ready", req_ready, 2'b01);
    next_cyc(); req_valid = '0; smp();
    check("t1_dc_valid", dc_req_valid, 1);
    check("t1_dc_addr", dc_addr, 32'h1000);
    check("t1_dc_we", dc_we, 0);
    check("t1_dc_size", dc_size, 2'd2);
    check("t1_ready_busy", req_ready, 0);
    next_cyc(); smp();
    check("t1_no_resp_t2", resp_valid, 0);
    next_cyc(); dc_rvalid = 1'b1; dc_rdata = 64'hDEADBEEF; smp();
    check("t1_no_resp_t3", resp_valid, 0);
    next_cyc(); dc_rvalid = 1'b0; dc_rdata = '0; smp();
    check("t1_resp_valid", resp_valid, 2'b01);
    check("t1_resp_data", resp_data, 64'h00000000DEADBEEF);
    check("t1_dc_idle", dc_req_valid, 0);
    check("t1_dc_addr_idle", dc_addr, 0);
    $display("txn t1 load req0 addr=0x1000 data=0x%0h", resp_data);
    next_cyc(); smp();
    check("t1_resp_pulse", resp_valid, 0);
    check("t1_resp_hold", resp_data, 64'hDEADBEEF);

    // Test 2: store on requester 1, then back-to-back store from the last-granted requester
    next_cyc();
    set_req(1'b1, 1'b1, 1'b1, 32'h2004, 64'h55, 2'd3);
    smp();
    check("t2_ready", req_ready, 2'b10);
    next_cyc(); req_valid = '0; smp();
    check("t2_dc_we", dc_we, 1);
    check("t2_dc_addr", dc_addr, 32'h2004);
    check("t2_dc_data", dc_wdata, 64'h55);
    check("t2_no_resp", resp_valid, 0);
    next_cyc();
    set_req(1'b1, 1'b1, 1'b1, 32'h2008, 64'h66, 2'd3);
    smp();
    check("t2_resp_valid", resp_valid, 2'b10);
    check("t2_resp_data", resp_data, 0);
    check("t2_dc_idle", dc_req_valid, 0);
    check("t2_regrant_last", req_ready, 2'b10);
    $display("txn t2 store req1 addr=0x2004");
    next_cyc(); req_valid = '0; smp();
    check("t2b_dc_addr", dc_addr, 32'h2008);

    // Test 3: both requesters stream stores; grants alternate 0,1,0,1
    next_cyc();
    set_req(1'b0, 1'b1, 1'b1, 32'h3000, 64'hA0, 2'd3);
    set_req(1'b1, 1'b1, 1'b1, 32'h3100, 64'hB1, 2'd3);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) next_cyc();
      smp();
      if (i % 2 == 0) exp_rdy = ((i / 2) % 2 == 0) ? 2'b01 : 2'b10;
      else            exp_rdy = 2'b00;
      check($sformatf("t3_ready_c%0d", i), req_ready, exp_rdy);
      if (i % 2 == 1) begin
        exp_a = (((i - 1) / 2) % 2 == 0) ? 32'h3000 : 32'h3100;
        check($sformatf("t3_addr_c%0d", i), dc_addr, exp_a);
      end
      if (i >= 2 && i % 2 == 0) begin
        exp_rsp = (((i - 2) / 2) % 2 == 0) ? 2'b01 : 2'b10;
        check($sformatf("t3_resp_c%0d", i), resp_valid, exp_rsp);
        $display("txn t3 store resp=%b", resp_valid);
      end
    end
    next_cyc(); req_valid = '0; smp();
    check("t3_drop_no_grant", req_ready, 0);
    check("t3_last_resp", resp_valid, 2'b10);

    // Test 4a: good load on requester 0, data at T+1
    next_cyc();
    set_req(1'b0, 1'b1, 1'b0, 32'h4000, 64'd0, 2'd3);
    smp();
    check("t4a_ready", req_ready, 2'b01);
    next_cyc(); req_valid = '0; dc_rvalid = 1'b1; dc_rdata = 64'h1122334455667788; smp();
    check("t4a_no_resp", resp_valid, 0);
    next_cyc(); dc_rvalid = 1'b0; dc_rdata = '0; smp();
    check("t4a_resp_valid", resp_valid, 2'b01);
    check("t4a_resp_data", resp_data, 64'h1122334455667788);
    check("t4a_timeout", timeout_err, 0);
    $display("txn t4a load req0 data=0x%0h", resp_data);

    // Test 4b: load on requester 1 never returns; aborted at T+6
    next_cyc();
    set_req(1'b1, 1'b1, 1'b0, 32'h4100, 64'd0, 2'd2);
    smp();
    check("t4b_ready", req_ready, 2'b10);
    for (int k = 1; k <= 5; k++) begin
      next_cyc();
      if (k == 1) req_valid = '0;
      smp();
      check($sformatf("t4b_no_resp_t%0d", k), resp_valid, 0);
      check($sformatf("t4b_no_err_t%0d", k), timeout_err, 0);
    end
    next_cyc(); smp();
    check("t4b_resp_valid", resp_valid, 2'b10);
    check("t4b_resp_data", resp_data, 0);
    check("t4b_timeout", timeout_err, 1);
    $display("txn t4b load req1 aborted by watchdog");
    next_cyc(); smp();
    check("t4b_err_sticky", timeout_err, 1);
    check("t4b_dc_idle", dc_req_valid, 0);

    // Test 4c: later good load keeps the sticky flag
    next_cyc();
    set_req(1'b0, 1'b1, 1'b0, 32'h4200, 64'd0, 2'd3);
    smp();
    check("t4c_ready", req_ready, 2'b01);
    next_cyc(); req_valid = '0; smp();
    next_cyc(); dc_rvalid = 1'b1; dc_rdata = 64'hCAFE; smp();
    next_cyc(); dc_rvalid = 1'b0; dc_rdata = '0; smp();
    check("t4c_resp_valid", resp_valid, 2'b01);
    check("t4c_resp_data", resp_data, 64'hCAFE);
    check("t4c_err_sticky", timeout_err, 1);
    $display("txn t4c load req0 data=0x%0h", resp_data);

    // Test 6: reset during a BUSY load drops it
    next_cyc();
    set_req(1'b1, 1'b1, 1'b0, 32'h5000, 64'd0, 2'd3);
    smp();
    check("t6_ready", req_ready, 2'b10);
    next_cyc(); req_valid = '0; smp();
    check("t6_dc_valid", dc_req_valid, 1);
    next_cyc(); rst_n = 1'b0; smp();
    next_cyc(); rst_n = 1'b1; dc_rvalid = 1'b1; dc_rdata = 64'h77; smp();
    check("t6_dc_cleared", dc_req_valid, 0);
    check("t6_addr_cleared", dc_addr, 0);
    check("t6_err_cleared", timeout_err, 0);
    check("t6_resp_data_cleared", resp_data, 0);
    check("t6_resp_none", resp_valid, 0);
    next_cyc(); dc_rvalid = 1'b0; dc_rdata = '0; smp();
    check("t6_late_data_ignored", resp_valid, 0);
    $display("txn t6 load req1 dropped by reset");

    // Test 5: first grant after reset goes to req0; data arrives as the counter hits the limit
    next_cyc();
    set_req(1'b0, 1'b1, 1'b0, 32'h6000, 64'd0, 2'd3);
    set_req(1'b1, 1'b1, 1'b0, 32'h6100, 64'd0, 2'd3);
    smp();
    check("t5_ready_after_reset", req_ready, 2'b01);
    for (int k = 1; k <= 4; k++) begin
      next_cyc();
      if (k == 1) req_valid = '0;
      smp();
      check($sformatf("t5_no_resp_t%0d", k), resp_valid, 0);
    end
    next_cyc(); dc_rvalid = 1'b1; dc_rdata = 64'hABCD; smp();
    check("t5_no_resp_t5", resp_valid, 0);
    next_cyc(); dc_rvalid = 1'b0; dc_rdata = '0; smp();
    check("t5_resp_valid", resp_valid, 2'b01);
    check("t5_resp_data", resp_data, 64'hABCD);
    check("t5_no_timeout", timeout_err, 0);
    $display("txn t5 load req0 data=0x%0h", resp_data);
    next_cyc(); smp();
    check("t5_no_timeout_after", timeout_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
